// File: rtl/obstacle_motion_gen_if.sv
// Control and position bus between the game top level and one obstacle generator.
interface obstacle_motion_gen_if #(
    parameter int unsigned X_W     = 8,
    parameter int unsigned Y_W     = 7,
    parameter int unsigned SPEED_W = 4
);
    logic               restart;
    logic               enable;
    logic               mode;
    logic [SPEED_W-1:0] speed;
    logic [X_W-1:0]     x_q;
    logic [Y_W-1:0]     y_q;
    logic [1:0]         lane_q;
    logic               wrap;

    // Game top level: drives control, consumes position.
    modport master (
        output restart, enable, mode, speed,
        input  x_q, y_q, lane_q, wrap
    );

    // Obstacle generator: consumes control, drives position.
    modport slave (
        input  restart, enable, mode, speed,
        output x_q, y_q, lane_q, wrap
    );
endinterface

// File: rtl/obstacle_motion_gen.sv
// Single-obstacle motion generator: falling y with wrap, x in lane or bounce mode.
module obstacle_motion_gen #(
    parameter int unsigned X_W      = 8,
    parameter int unsigned Y_W      = 7,
    parameter int unsigned Y_TOP    = 119,
    parameter int unsigned Y_INIT   = 119,
    parameter int unsigned X_MIN    = 1,
    parameter int unsigned X_MAX    = 119,
    parameter int unsigned LANE0    = 2,
    parameter int unsigned LANE1    = 40,
    parameter int unsigned LANE2    = 20,
    parameter int unsigned LANE3    = 30,
    parameter bit          DIR_INIT = 1'b1,
    parameter int unsigned SPEED_W  = 4,
    parameter logic [7:0]  SEED     = 8'hA5
) (
    input  logic                  clock,
    input  logic                  resetn,
    obstacle_motion_gen_if.slave  bus
);

    localparam logic [Y_W-1:0] Y_TOP_V  = Y_W'(Y_TOP);
    localparam logic [Y_W-1:0] Y_INIT_V = Y_W'(Y_INIT);
    localparam logic [X_W-1:0] X_MIN_V  = X_W'(X_MIN);
    localparam logic [X_W-1:0] X_MAX_V  = X_W'(X_MAX);
    localparam logic [X_W-1:0] LANE0_V  = X_W'(LANE0);
    localparam logic [X_W-1:0] LANE1_V  = X_W'(LANE1);
    localparam logic [X_W-1:0] LANE2_V  = X_W'(LANE2);
    localparam logic [X_W-1:0] LANE3_V  = X_W'(LANE3);

    logic               dir_q;
    logic [7:0]         lfsr_q;
    logic [SPEED_W-1:0] div_q;

    logic               div_hit_c;
    logic               step_c;
    logic               y_zero_c;
    logic [7:0]         lfsr_next_c;
    logic [X_W-1:0]     bounce_x_c;
    logic               bounce_dir_c;

    // Lane index to column lookup.
    function automatic logic [X_W-1:0] lane_col(input logic [1:0] idx);
        logic [X_W-1:0] col;
        case (idx)
            2'd0:    col = LANE0_V;
            2'd1:    col = LANE1_V;
            2'd2:    col = LANE2_V;
            default: col = LANE3_V;
        endcase
        return col;
    endfunction

    // Step qualification; restart suppresses any step on the same cycle.
    always_comb begin
        div_hit_c   = (div_q == bus.speed);
        step_c      = bus.enable & ~bus.restart & div_hit_c;
        y_zero_c    = (bus.y_q == '0);
        lfsr_next_c = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end

    // Bounce next position; reversal moves away from the limit in the same step.
    always_comb begin
        bounce_dir_c = dir_q;
        bounce_x_c   = bus.x_q;
        if (dir_q) begin
            if (bus.x_q >= X_MAX_V) begin
                bounce_dir_c = 1'b0;
                bounce_x_c   = bus.x_q - X_W'(1);
            end else begin
                bounce_x_c   = bus.x_q + X_W'(1);
            end
        end else begin
            if (bus.x_q <= X_MIN_V) begin
                bounce_dir_c = 1'b1;
                bounce_x_c   = bus.x_q + X_W'(1);
            end else begin
                bounce_x_c   = bus.x_q - X_W'(1);
            end
        end
    end

    // Enable divider; counts modulo 2^SPEED_W so a lowered speed still gets matched.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            div_q <= '0;
        end else if (bus.restart) begin
            div_q <= '0;
        end else if (bus.enable) begin
            div_q <= div_hit_c ? '0 : div_q + SPEED_W'(1);
        end
    end

    // LFSR advances only on steps.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            lfsr_q <= SEED;
        end else if (bus.restart) begin
            lfsr_q <= SEED;
        end else if (step_c) begin
            lfsr_q <= lfsr_next_c;
        end
    end

    // Vertical fall with explicit wrap to the top row and a one-cycle wrap pulse.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            bus.y_q  <= Y_INIT_V;
            bus.wrap <= 1'b0;
        end else if (bus.restart) begin
            bus.y_q  <= Y_INIT_V;
            bus.wrap <= 1'b0;
        end else begin
            bus.wrap <= step_c & y_zero_c;
            if (step_c) begin
                bus.y_q <= y_zero_c ? Y_TOP_V : bus.y_q - Y_W'(1);
            end
        end
    end

    // Horizontal position, lane choice and bounce direction.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            bus.x_q    <= LANE0_V;
            bus.lane_q <= 2'd0;
            dir_q      <= DIR_INIT;
        end else if (bus.restart) begin
            bus.x_q    <= LANE0_V;
            bus.lane_q <= 2'd0;
            dir_q      <= DIR_INIT;
        end else if (step_c) begin
            if (bus.mode) begin
                bus.x_q <= bounce_x_c;
                dir_q   <= bounce_dir_c;
            end else if (y_zero_c) begin
                bus.lane_q <= lfsr_q[1:0];
                bus.x_q    <= lane_col(lfsr_q[1:0]);
            end else begin
                bus.x_q <= lane_col(bus.lane_q);
            end
        end
    end

endmodule

// File: tb/tb_obstacle_motion_gen.sv
// Directed bench for obstacle_motion_gen: default instance plus two bounce-limit instances.
module tb_obstacle_motion_gen;

    logic       clock;
    logic       resetn;
    logic       restart;
    logic       enable;
    logic       mode;
    logic [3:0] speed;

    int vectors;
    int miscompares;

    // Reference state for the default-parameter instance.
    logic [7:0] m_x;
    logic [6:0] m_y;
    logic [1:0] m_lane;
    logic       m_dir;
    logic [7:0] m_lfsr;
    logic [3:0] m_div;
    logic       m_wrap;

    obstacle_motion_gen_if #(.X_W(8), .Y_W(7), .SPEED_W(4)) bus_a ();
    obstacle_motion_gen_if #(.X_W(8), .Y_W(7), .SPEED_W(4)) bus_b ();
    obstacle_motion_gen_if #(.X_W(8), .Y_W(7), .SPEED_W(4)) bus_c ();

    assign bus_a.restart = restart;
    assign bus_a.enable  = enable;
    assign bus_a.mode    = mode;
    assign bus_a.speed   = speed;
    assign bus_b.restart = restart;
    assign bus_b.enable  = enable;
    assign bus_b.mode    = mode;
    assign bus_b.speed   = speed;
    assign bus_c.restart = restart;
    assign bus_c.enable  = enable;
    assign bus_c.mode    = mode;
    assign bus_c.speed   = speed;

    obstacle_motion_gen dut_a (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus_a)
    );

    obstacle_motion_gen #(.LANE0(117), .DIR_INIT(1'b1)) dut_b (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus_b)
    );

    obstacle_motion_gen #(.LANE0(3), .DIR_INIT(1'b0)) dut_c (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus_c)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    function automatic logic [7:0] lfsr_adv(input logic [7:0] l);
        // x^8 + x^6 + x^5 + x^4 + 1 -> taps on bits 7,5,4,3
        return {l[6:0], ^(l & 8'b1011_1000)};
    endfunction

    function automatic logic [7:0] lane_x(input logic [1:0] idx);
        logic [7:0] c;
        case (idx)
            2'd0:    c = 8'd2;
            2'd1:    c = 8'd40;
            2'd2:    c = 8'd20;
            default: c = 8'd30;
        endcase
        return c;
    endfunction

    task automatic model_reset();
        m_x    = 8'd2;
        m_y    = 7'd119;
        m_lane = 2'd0;
        m_dir  = 1'b1;
        m_lfsr = 8'hA5;
        m_div  = 4'd0;
        m_wrap = 1'b0;
    endtask

    // Advance the reference by one clock using the inputs currently applied.
    task automatic model_clock();
        logic [7:0] pre;
        logic       wrapped;
        if (restart) begin
            model_reset();
        end else begin
            m_wrap = 1'b0;
            if (enable) begin
                if (m_div == speed) begin
                    m_div   = 4'd0;
                    pre     = m_lfsr;
                    m_lfsr  = lfsr_adv(pre);
                    wrapped = (m_y == 7'd0);
                    m_wrap  = wrapped;
                    if (wrapped) m_y = 7'd119;
                    else         m_y = m_y - 7'd1;
                    if (!mode) begin
                        if (wrapped) m_lane = pre[1:0];
                        m_x = lane_x(m_lane);
                    end else if (m_dir && m_x >= 8'd119) begin
                        m_dir = 1'b0;
                        m_x   = m_x - 8'd1;
                    end else if (!m_dir && m_x <= 8'd1) begin
                        m_dir = 1'b1;
                        m_x   = m_x + 8'd1;
                    end else if (m_dir) begin
                        m_x = m_x + 8'd1;
                    end else begin
                        m_x = m_x - 8'd1;
                    end
                end else begin
                    m_div = m_div + 4'd1;
                end
            end
        end
    endtask

    task automatic tick();
        model_clock();
        @(posedge clock);
        #1;
    endtask

    task automatic pulse();
        enable = 1'b1;
        tick();
        enable = 1'b0;
        tick();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_model(input string tag);
        chk({tag, "_x"},    32'(bus_a.x_q),    32'(m_x));
        chk({tag, "_y"},    32'(bus_a.y_q),    32'(m_y));
        chk({tag, "_lane"}, 32'(bus_a.lane_q), 32'(m_lane));
        chk({tag, "_wrap"}, 32'(bus_a.wrap),   32'(m_wrap));
    endtask

    logic [7:0] exp_hi [5];
    logic [7:0] exp_lo [3];
    bit         found;

    initial begin
        vectors     = 0;
        miscompares = 0;
        exp_hi      = '{8'd118, 8'd119, 8'd118, 8'd117, 8'd116};
        exp_lo      = '{8'd2, 8'd1, 8'd2};
        found       = 1'b0;
        resetn      = 1'b0;
        restart     = 1'b0;
        enable      = 1'b0;
        mode        = 1'b0;
        speed       = 4'd0;
        model_reset();

        // Reset values, asynchronously visible
        #12;
        chk("rst_x",    32'(bus_a.x_q),    32'd2);
        chk("rst_y",    32'(bus_a.y_q),    32'd119);
        chk("rst_lane", 32'(bus_a.lane_q), 32'd0);
        chk("rst_wrap", 32'(bus_a.wrap),   32'd0);

        // Release, idle with enable low
        @(negedge clock);
        resetn = 1'b1;
        repeat (10) tick();
        chk("idle_x",    32'(bus_a.x_q),    32'd2);
        chk("idle_y",    32'(bus_a.y_q),    32'd119);
        chk("idle_lane", 32'(bus_a.lane_q), 32'd0);
        chk("idle_wrap", 32'(bus_a.wrap),   32'd0);

        // Lane-mode fall at full speed over 20 wraps
        enable = 1'b1;
        for (int w = 0; w < 20; w++) begin
            tick();
            chk("fall_y118",  32'(bus_a.y_q),  32'd118);
            chk("fall_nowrap", 32'(bus_a.wrap), 32'd0);
            repeat (118) tick();
            chk("fall_y0",    32'(bus_a.y_q),  32'd0);
            chk("fall_wrap0", 32'(bus_a.wrap), 32'd0);
            tick();
            chk("wrap_y",     32'(bus_a.y_q),  32'd119);
            chk("wrap_pulse", 32'(bus_a.wrap), 32'd1);
            chk_model("wrap_lane");
        end

        // Divider: speed 3, enable every other clock for 32 clocks
        enable = 1'b0;
        speed  = 4'd3;
        tick();
        repeat (16) pulse();
        chk("div_y115", 32'(bus_a.y_q),  32'd115);
        chk("div_wrap", 32'(bus_a.wrap), 32'd0);
        chk_model("div");

        // Speed lowered to 0 with div_cnt at 2: wraps through 15 before matching
        repeat (2) pulse();
        speed = 4'd0;
        repeat (14) pulse();
        chk("spd_hold", 32'(bus_a.y_q), 32'd115);
        pulse();
        chk("spd_step", 32'(bus_a.y_q), 32'd114);
        chk_model("spd");

        // Restart beats enable at y=50
        enable = 1'b1;
        repeat (64) tick();
        chk("pri_y50", 32'(bus_a.y_q), 32'd50);
        restart = 1'b1;
        tick();
        restart = 1'b0;
        enable  = 1'b0;
        chk("pri_y",    32'(bus_a.y_q),    32'd119);
        chk("pri_wrap", 32'(bus_a.wrap),   32'd0);
        chk("pri_x",    32'(bus_a.x_q),    32'd2);
        chk("pri_lane", 32'(bus_a.lane_q), 32'd0);

        // Reset mid-count clears the divider
        speed = 4'd2;
        repeat (2) pulse();
        chk("mid_y", 32'(bus_a.y_q), 32'd119);
        #2;
        resetn = 1'b0;
        model_reset();
        @(negedge clock);
        resetn = 1'b1;
        repeat (2) pulse();
        chk("rel_hold", 32'(bus_a.y_q), 32'd119);
        pulse();
        chk("rel_step", 32'(bus_a.y_q), 32'd118);
        chk_model("rel");

        // Bounce at both limits
        speed   = 4'd0;
        mode    = 1'b1;
        restart = 1'b1;
        tick();
        restart = 1'b0;
        chk("bnc_start_hi", 32'(bus_b.x_q), 32'd117);
        chk("bnc_start_lo", 32'(bus_c.x_q), 32'd3);
        enable = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bnc_hi", 32'(bus_b.x_q), 32'(exp_hi[i]));
            if (i < 3) chk("bnc_lo", 32'(bus_c.x_q), 32'(exp_lo[i]));
        end
        chk_model("bnc_a");

        // Mode switch: find a wrap that selects lane 1, bounce, then snap back
        mode    = 1'b0;
        restart = 1'b1;
        tick();
        restart = 1'b0;
        for (int w = 0; w < 40 && !found; w++) begin
            repeat (120) tick();
            if (m_lane == 2'd1) found = 1'b1;
        end
        chk_model("sw_lane");
        mode = 1'b1;
        repeat (33) tick();
        chk_model("sw_bnc");
        if (found) chk("sw_x73", 32'(bus_a.x_q), 32'd73);
        mode = 1'b0;
        tick();
        chk_model("sw_snap");
        if (found) chk("sw_x40", 32'(bus_a.x_q), 32'd40);

        // Wrap timing after the switch
        repeat (85) tick();
        chk("sw_y0",    32'(bus_a.y_q),  32'd0);
        chk("sw_wrap0", 32'(bus_a.wrap), 32'd0);
        tick();
        chk("sw_wrap1", 32'(bus_a.wrap), 32'd1);
        chk_model("sw_wrap");
        enable = 1'b0;
        tick();
        chk("sw_wrapend", 32'(bus_a.wrap), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
